serdes_align_ctrl: RTL and testbench

Word-alignment controller for a Spartan-6 style input SERDES lane fed by a BUFIO2 divided clock and strobe. Runs in the DIVCLK domain and consumes the deserialized word stream. Issues single-cycle BITSLIP pulses until TRAIN_PATTERN is received repeatedly, then holds lock and watches for loss of alignment. Sits between the ISERDES datapath and the link/capture logic, which waits on `aligned` before using data.

---
 rtl/serdes_align_ctrl.sv | 163 ++++++++++++++++
 tb/tb_serdes_align_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_align_ctrl.sv
// Word-alignment controller for one ISERDES lane in the DIVCLK domain.
// It pulses BITSLIP until the training word repeats, then holds lock and watches for drift.
module serdes_align_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [7:0]  TRAIN_PATTERN = 8'h1E,
    parameter int unsigned SETTLE_WORDS  = 4,
    parameter int unsigned MATCH_WORDS   = 16,
    parameter int unsigned LOSS_WORDS    = 4
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  start,
    input  logic                  auto_retrain,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  bitslip,
    output logic                  aligned,
    output logic                  fail,
    output logic                  busy,
    output logic [3:0]            slip_count
);

    localparam logic [DATA_WIDTH-1:0] PATTERN     = TRAIN_PATTERN[DATA_WIDTH-1:0];
    localparam logic [3:0]            SETTLE_N    = 4'(SETTLE_WORDS);
    localparam logic [7:0]            MATCH_N     = 8'(MATCH_WORDS);
    localparam logic [3:0]            LOSS_N      = 4'(LOSS_WORDS);
    localparam logic [3:0]            SLIP_BUDGET = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t     r_state;
    logic [3:0] r_settle_cnt;
    logic [7:0] r_match_cnt;
    logic [3:0] r_loss_cnt;
    logic [3:0] r_slip_count;
    logic       r_bitslip;
    logic       r_aligned;
    logic       r_fail;
    logic       r_busy;

    logic       w_match;
    logic [3:0] w_settle_inc;
    logic [7:0] w_match_inc;
    logic [3:0] w_loss_inc;

    assign w_match      = (din == PATTERN);
    assign w_settle_inc = r_settle_cnt + 4'd1;
    assign w_match_inc  = r_match_cnt + 8'd1;
    assign w_loss_inc   = r_loss_cnt + 4'd1;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= 4'd0;
            r_match_cnt  <= 8'd0;
            r_loss_cnt   <= 4'd0;
            r_slip_count <= 4'd0;
            r_bitslip    <= 1'b0;
            r_aligned    <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // The slip request is a single-cycle pulse; a pulse already in flight
            // finishes even when start restarts training.
            r_bitslip <= 1'b0;
            if (start) begin
                r_state      <= S_SETTLE;
                r_settle_cnt <= 4'd0;
                r_match_cnt  <= 8'd0;
                r_loss_cnt   <= 4'd0;
                r_slip_count <= 4'd0;
                r_aligned    <= 1'b0;
                r_fail       <= 1'b0;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_SETTLE: begin
                        if (din_valid) begin
                            if (w_settle_inc == SETTLE_N) begin
                                r_state      <= S_CHECK;
                                r_settle_cnt <= 4'd0;
                                r_match_cnt  <= 8'd0;
                            end else begin
                                r_settle_cnt <= w_settle_inc;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (din_valid) begin
                            if (w_match) begin
                                if (w_match_inc == MATCH_N) begin
                                    r_state    <= S_LOCKED;
                                    r_loss_cnt <= 4'd0;
                                    r_aligned  <= 1'b1;
                                    r_busy     <= 1'b0;
                                end else begin
                                    r_match_cnt <= w_match_inc;
                                end
                            end else if (r_slip_count < SLIP_BUDGET) begin
                                r_state   <= S_SLIP;
                                r_bitslip <= 1'b1;
                            end else begin
                                r_state <= S_FAIL;
                                r_fail  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_SLIP: begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= 4'd0;
                        if (r_slip_count != 4'hF) begin
                            r_slip_count <= r_slip_count + 4'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (din_valid) begin
                            if (w_match) begin
                                r_loss_cnt <= 4'd0;
                            end else if (w_loss_inc == LOSS_N) begin
                                r_loss_cnt <= 4'd0;
                                r_aligned  <= 1'b0;
                                if (auto_retrain) begin
                                    r_state      <= S_SETTLE;
                                    r_settle_cnt <= 4'd0;
                                    r_slip_count <= 4'd0;
                                    r_busy       <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_loss_cnt <= w_loss_inc;
                            end
                        end
                    end
                    S_FAIL: begin
                        r_fail <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bitslip    = r_bitslip;
    assign aligned    = r_aligned;
    assign fail       = r_fail;
    assign busy       = r_busy;
    assign slip_count = r_slip_count;

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Bench for serdes_align_ctrl: a rotating-lane ISERDES model plus a phase-walking
// reference that predicts slip times and the lock/fail cycle from the valid trace.
module tb_serdes_align_ctrl;

    localparam int         DW  = 8;
    localparam logic [7:0] PAT = 8'h1E;
    localparam int         SW  = 4;
    localparam int         MW  = 16;
    localparam int         N   = 600;

    logic       clk          = 1'b0;
    logic       resetb       = 1'b0;
    logic       start        = 1'b0;
    logic       auto_retrain = 1'b0;
    logic       din_valid    = 1'b0;
    logic [7:0] din          = 8'h00;
    logic       bitslip;
    logic       aligned;
    logic       fail;
    logic       busy;
    logic [3:0] slip_count;

    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         n_double = 0;
    bit         prev_bs  = 1'b0;
    logic [7:0] lane_word   = PAT;
    int         lane_rot    = 0;
    bit         inject_en   = 1'b0;
    logic [7:0] inject_word = 8'h00;
    bit         vtrace[N];

    int         m_done;
    int         m_slips;
    int         m_slip_at[16];
    bit         m_lock;
    int         obs_lock;
    int         obs_fail;
    int         obs_pulses;
    int         obs_slip_at[16];
    logic       obs_busy_start;
    logic       obs_busy_pre;
    logic       obs_busy_done;

    serdes_align_ctrl #(
        .DATA_WIDTH   (DW),
        .TRAIN_PATTERN(PAT),
        .SETTLE_WORDS (SW),
        .MATCH_WORDS  (MW),
        .LOSS_WORDS   (4)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .start       (start),
        .auto_retrain(auto_retrain),
        .din         (din),
        .din_valid   (din_valid),
        .bitslip     (bitslip),
        .aligned     (aligned),
        .fail        (fail),
        .busy        (busy),
        .slip_count  (slip_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, summary required");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < n % 8; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // One clock of the lane: every observed slip pulse rotates the lane by one bit.
    task automatic step(input logic s, input logic v);
        start     = s;
        din_valid = v;
        din       = inject_en ? inject_word : rotl(lane_word, lane_rot);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (bitslip === 1'b1) begin
            if (prev_bs) n_double++;
            lane_rot++;
        end
        prev_bs = (bitslip === 1'b1);
    endtask

    task automatic fill_trace(input int pct, input bit toggle);
        for (int i = 0; i < N; i++)
            vtrace[i] = toggle ? (i % 2 == 0) : (int'($urandom_range(99)) < pct);
    endtask

    // Phases per attempt: discard SW valid words, judge the next valid word,
    // then either count MW matches, give up after DW slips, or spend one slip cycle.
    task automatic model_train(input logic [7:0] w);
        int pos;
        int rot;
        int seen;
        int got;
        pos = 0; rot = 0;
        m_done = -1; m_slips = 0; m_lock = 1'b0;
        while (pos < N && m_done < 0) begin
            seen = 0;
            while (seen < SW && pos < N) begin
                if (vtrace[pos]) seen++;
                pos++;
            end
            while (pos < N && !vtrace[pos]) pos++;
            if (pos >= N) break;
            if (rotl(w, rot) == PAT) begin
                got = 0;
                while (pos < N && m_done < 0) begin
                    if (vtrace[pos]) begin
                        got++;
                        if (got == MW) begin
                            m_done = pos;
                            m_lock = 1'b1;
                        end
                    end
                    pos++;
                end
            end else if (m_slips == DW) begin
                m_done = pos;
            end else begin
                m_slip_at[m_slips] = pos;
                m_slips++;
                rot++;
                pos += 2;
            end
        end
    endtask

    task automatic run_train(input logic [7:0] w, input bit do_start);
        model_train(w);
        lane_word = w; lane_rot = 0; inject_en = 1'b0;
        obs_lock = -1; obs_fail = -1; obs_pulses = 0;
        obs_busy_pre = 1'bx; obs_busy_done = 1'bx;
        if (do_start) begin
            step(1'b1, 1'b0);
            obs_busy_start = busy;
        end
        for (int i = 0; i < N; i++) begin
            step(1'b0, vtrace[i]);
            if (bitslip === 1'b1) begin
                if (obs_pulses < 16) obs_slip_at[obs_pulses] = i;
                obs_pulses++;
            end
            if (aligned === 1'b1 && obs_lock < 0) obs_lock = i;
            if (fail === 1'b1 && obs_fail < 0) obs_fail = i;
            if (i == m_done - 1) obs_busy_pre = busy;
            if (i == m_done) obs_busy_done = busy;
            if (m_done >= 0 && i > m_done) break;
        end
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bitslip, aligned, fail, busy, slip_count} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 00", {bitslip, aligned, fail, busy, slip_count});
        end
        @(negedge clk);
        resetb = 1'b1;
        repeat (3) step(1'b0, 1'b1);
        n_cmp++;
        if ({bitslip, aligned, fail, busy, slip_count} !== 8'h00) begin
            n_bad++;
            $display("FAIL idle_without_start: got %h want 00", {bitslip, aligned, fail, busy, slip_count});
        end
        $display("reset: outputs %h", {bitslip, aligned, fail, busy, slip_count});
    endtask

    task automatic test_aligned;
        fill_trace(100, 1'b0);
        run_train(PAT, 1'b1);
        n_cmp++;
        if (obs_busy_start !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", obs_busy_start); end
        n_cmp++;
        if (obs_lock !== m_done) begin n_bad++; $display("FAIL aligned_lock_cycle: got %0d want %0d", obs_lock, m_done); end
        n_cmp++;
        if (obs_busy_pre !== 1'b1 || obs_busy_done !== 1'b0) begin
            n_bad++; $display("FAIL aligned_busy_edge: got %b%b want 10", obs_busy_pre, obs_busy_done);
        end
        n_cmp++;
        if (obs_pulses !== 0 || slip_count !== 4'd0) begin
            n_bad++; $display("FAIL aligned_no_slip: got pulses %0d count %0d want 0 0", obs_pulses, slip_count);
        end
        $display("aligned: lock at word-cycle %0d, slips %0d", obs_lock, obs_pulses);
    endtask

    task automatic test_rotated;
        fill_trace(100, 1'b0);
        run_train(8'hC3, 1'b1);
        n_cmp++;
        if (obs_pulses !== m_slips) begin n_bad++; $display("FAIL rot_pulse_count: got %0d want %0d", obs_pulses, m_slips); end
        for (int j = 0; j < m_slips && j < obs_pulses; j++) begin
            n_cmp++;
            if (obs_slip_at[j] !== m_slip_at[j]) begin
                n_bad++; $display("FAIL rot_slip_time[%0d]: got %0d want %0d", j, obs_slip_at[j], m_slip_at[j]);
            end
        end
        n_cmp++;
        if (obs_lock !== m_done || aligned !== 1'b1) begin
            n_bad++; $display("FAIL rot_lock: got cycle %0d aligned %b want %0d 1", obs_lock, aligned, m_done);
        end
        n_cmp++;
        if (slip_count !== 4'(m_slips)) begin n_bad++; $display("FAIL rot_slip_count: got %0d want %0d", slip_count, m_slips); end
        n_cmp++;
        if (n_double !== 0) begin n_bad++; $display("FAIL rot_single_cycle_pulse: got %0d wide pulses want 0", n_double); end
        $display("rotated: word c3 slips %0d lock %0d", obs_pulses, obs_lock);
    endtask

    task automatic test_unlockable;
        fill_trace(100, 1'b0);
        run_train(8'hFF, 1'b1);
        n_cmp++;
        if (obs_fail !== m_done) begin n_bad++; $display("FAIL unl_fail_cycle: got %0d want %0d", obs_fail, m_done); end
        n_cmp++;
        if (obs_pulses !== m_slips) begin n_bad++; $display("FAIL unl_pulses: got %0d want %0d", obs_pulses, m_slips); end
        n_cmp++;
        if (slip_count !== 4'(m_slips) || aligned !== 1'b0 || obs_busy_done !== 1'b0) begin
            n_bad++; $display("FAIL unl_outputs: got count %0d aligned %b busy %b want %0d 0 0", slip_count, aligned, obs_busy_done, m_slips);
        end
        repeat (20) step(1'b0, 1'b1);
        n_cmp++;
        if (fail !== 1'b1 || bitslip !== 1'b0) begin n_bad++; $display("FAIL unl_fail_holds: got fail %b bitslip %b want 1 0", fail, bitslip); end
        step(1'b1, 1'b0);
        n_cmp++;
        if (fail !== 1'b0 || busy !== 1'b1 || slip_count !== 4'd0) begin
            n_bad++; $display("FAIL unl_start_clears: got fail %b busy %b count %0d want 0 1 0", fail, busy, slip_count);
        end
        $display("unlockable: fail at %0d after %0d slips", obs_fail, obs_pulses);
    endtask

    task automatic test_gapped;
        fill_trace(0, 1'b1);
        run_train(PAT, 1'b1);
        n_cmp++;
        if (obs_lock !== m_done) begin n_bad++; $display("FAIL gap_lock_cycle: got %0d want %0d", obs_lock, m_done); end
        n_cmp++;
        if (obs_lock !== 2 * (SW + MW) - 2) begin n_bad++; $display("FAIL gap_doubled: got %0d want %0d", obs_lock, 2 * (SW + MW) - 2); end
        $display("gapped: lock at word-cycle %0d", obs_lock);
    endtask

    task automatic test_loss;
        int k;
        fill_trace(100, 1'b0);
        auto_retrain = 1'b1;
        run_train(PAT, 1'b1);
        n_cmp++;
        if (aligned !== 1'b1) begin n_bad++; $display("FAIL loss_pre_lock: got %b want 1", aligned); end
        inject_en = 1'b1; inject_word = 8'h00;
        repeat (3) step(1'b0, 1'b1);
        n_cmp++;
        if (aligned !== 1'b1) begin n_bad++; $display("FAIL loss_three_bad_hold: got %b want 1", aligned); end
        step(1'b0, 1'b1);
        n_cmp++;
        if (aligned !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL loss_fourth_drops: got aligned %b busy %b want 0 1", aligned, busy);
        end
        inject_en = 1'b0;
        for (k = 0; k < 60 && aligned !== 1'b1; k++) step(1'b0, 1'b1);
        n_cmp++;
        if (k !== SW + MW || slip_count !== 4'd0) begin
            n_bad++; $display("FAIL loss_relock: got %0d cycles count %0d want %0d 0", k, slip_count, SW + MW);
        end
        inject_en = 1'b1; repeat (3) step(1'b0, 1'b1);
        inject_en = 1'b0; step(1'b0, 1'b1);
        inject_en = 1'b1; repeat (3) step(1'b0, 1'b1);
        n_cmp++;
        if (aligned !== 1'b1) begin n_bad++; $display("FAIL loss_cleared_by_match: got %b want 1", aligned); end
        auto_retrain = 1'b0;
        step(1'b0, 1'b1);
        n_cmp++;
        if (aligned !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL loss_noretrain_idle: got aligned %b busy %b want 0 0", aligned, busy);
        end
        inject_en = 1'b0;
        repeat (30) step(1'b0, 1'b1);
        n_cmp++;
        if (aligned !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_stays_idle: got aligned %b busy %b want 0 0", aligned, busy);
        end
        $display("loss: relock after %0d cycles", k);
    endtask

    task automatic test_start_during_slip;
        int k;
        int dbl0;
        fill_trace(100, 1'b0);
        lane_word = 8'hC3; lane_rot = 0; inject_en = 1'b0;
        dbl0 = n_double;
        step(1'b1, 1'b0);
        for (k = 0; k < 50 && bitslip !== 1'b1; k++) step(1'b0, 1'b1);
        n_cmp++;
        if (bitslip !== 1'b1) begin n_bad++; $display("FAIL sds_pulse_seen: got %b want 1", bitslip); end
        step(1'b1, 1'b1);
        n_cmp++;
        if (bitslip !== 1'b0 || slip_count !== 4'd0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL sds_restart: got bitslip %b count %0d busy %b want 0 0 1", bitslip, slip_count, busy);
        end
        run_train(rotl(8'hC3, lane_rot), 1'b0);
        n_cmp++;
        if (obs_pulses !== m_slips || obs_lock !== m_done) begin
            n_bad++; $display("FAIL sds_retrain: got pulses %0d lock %0d want %0d %0d", obs_pulses, obs_lock, m_slips, m_done);
        end
        n_cmp++;
        if (slip_count !== 4'(m_slips) || n_double !== dbl0) begin
            n_bad++; $display("FAIL sds_count: got %0d wide %0d want %0d 0", slip_count, n_double - dbl0, m_slips);
        end
        $display("start_during_slip: restart then %0d slips, lock %0d", obs_pulses, obs_lock);
    endtask

    task automatic test_reset_mid;
        int k;
        lane_word = PAT; lane_rot = 0; inject_en = 1'b0;
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        #2 resetb = 1'b0;
        #1;
        n_cmp++;
        if ({bitslip, aligned, fail, busy, slip_count} !== 8'h00) begin
            n_bad++; $display("FAIL rst_mid_check: got %h want 00", {bitslip, aligned, fail, busy, slip_count});
        end
        @(negedge clk);
        resetb = 1'b1;
        lane_word = 8'hFF; lane_rot = 0;
        step(1'b1, 1'b0);
        for (k = 0; k < 50 && bitslip !== 1'b1; k++) step(1'b0, 1'b1);
        n_cmp++;
        if (bitslip !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pulse_seen: got %b want 1", bitslip); end
        #2 resetb = 1'b0;
        #1;
        n_cmp++;
        if ({bitslip, aligned, fail, busy, slip_count} !== 8'h00) begin
            n_bad++; $display("FAIL rst_mid_bitslip: got %h want 00", {bitslip, aligned, fail, busy, slip_count});
        end
        @(negedge clk);
        resetb  = 1'b1;
        prev_bs = 1'b0;
        $display("reset_mid: outputs cleared asynchronously");
    endtask

    task automatic test_random;
        logic [7:0] w;
        int         k;
        int         pct;
        int         got_done;
        int         other;
        for (int t = 0; t < 8; t++) begin
            k = int'($urandom_range(0, 7));
            if (t % 2 == 0) w = rotl(PAT, 8 - k);
            else            w = 8'($urandom_range(0, 255));
            auto_retrain = 1'($urandom_range(0, 1));
            pct = int'($urandom_range(50, 100));
            fill_trace(pct, 1'b0);
            run_train(w, 1'b1);
            got_done = m_lock ? obs_lock : obs_fail;
            other    = m_lock ? obs_fail : obs_lock;
            n_cmp++;
            if (got_done !== m_done || other !== -1) begin
                n_bad++; $display("FAIL rand_done[%0d]: got %0d/%0d want %0d/-1", t, got_done, other, m_done);
            end
            n_cmp++;
            if (obs_pulses !== m_slips || slip_count !== 4'(m_slips)) begin
                n_bad++; $display("FAIL rand_slips[%0d]: got pulses %0d count %0d want %0d", t, obs_pulses, slip_count, m_slips);
            end
            for (int j = 0; j < m_slips && j < obs_pulses && j < 16; j++) begin
                n_cmp++;
                if (obs_slip_at[j] !== m_slip_at[j]) begin
                    n_bad++; $display("FAIL rand_slip_time[%0d.%0d]: got %0d want %0d", t, j, obs_slip_at[j], m_slip_at[j]);
                end
            end
            $display("random %0d: word %h valid %0d%% lock %0d slips %0d done %0d", t, w, pct, m_lock, obs_pulses, got_done);
        end
        n_cmp++;
        if (n_double !== 0) begin n_bad++; $display("FAIL pulse_width_total: got %0d wide pulses want 0", n_double); end
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_rotated;
        test_unlockable;
        test_gapped;
        test_loss;
        test_start_during_slip;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
